// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout FSM with inventory; optional low-stock flags via CHANGE_LOW_STOCK_EN
module change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 8,
  parameter int INIT_N50   = 4,
  parameter int INIT_N10   = 10,
  parameter int INIT_N5    = 10,
  parameter int INIT_N1    = 20,
  parameter int LOW_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             refill,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic [AMT_W-1:0] coin_value,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [AMT_W-1:0] remaining,
  output logic [3:0]       low_stock
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam logic [AMT_W-1:0] D50 = AMT_W'(50);
  localparam logic [AMT_W-1:0] D10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] D5  = AMT_W'(5);
  localparam logic [AMT_W-1:0] D1  = AMT_W'(1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] n50, n10, n5, n1;
  logic [AMT_W-1:0] sel_value;
  logic             sel_found;

  // Largest denomination that fits the remaining amount and is still in stock
  always_comb begin
    sel_found = 1'b1;
    sel_value = '0;
    if (remaining >= D50 && n50 != '0)     sel_value = D50;
    else if (remaining >= D10 && n10 != '0) sel_value = D10;
    else if (remaining >= D5 && n5 != '0)   sel_value = D5;
    else if (remaining >= D1 && n1 != '0)   sel_value = D1;
    else                                    sel_found = 1'b0;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; ISSUE always has coin_valid high, so coin_ready alone marks the handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (req_valid) state_next = (req_amount == '0) ? DONE : SELECT;
      SELECT: state_next = sel_found ? ISSUE : DONE;
      ISSUE:  if (coin_ready) state_next = (remaining == coin_value) ? DONE : SELECT;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Amount, coin presentation and inventory bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining  <= '0;
      shortfall  <= '0;
      coin_valid <= 1'b0;
      coin_value <= '0;
      n50        <= CNT_W'(INIT_N50);
      n10        <= CNT_W'(INIT_N10);
      n5         <= CNT_W'(INIT_N5);
      n1         <= CNT_W'(INIT_N1);
    end else begin
      case (state)
        IDLE: begin
          if (refill) begin
            n50 <= CNT_W'(INIT_N50);
            n10 <= CNT_W'(INIT_N10);
            n5  <= CNT_W'(INIT_N5);
            n1  <= CNT_W'(INIT_N1);
          end
          if (req_valid) begin
            remaining <= req_amount;
            shortfall <= '0;
          end
        end
        SELECT: begin
          if (sel_found) begin
            coin_value <= sel_value;
            coin_valid <= 1'b1;
          end else begin
            shortfall <= remaining;
          end
        end
        ISSUE: begin
          if (coin_ready) begin
            remaining  <= remaining - coin_value;
            coin_valid <= 1'b0;
            if (coin_value == D50)      n50 <= n50 - ONE;
            else if (coin_value == D10) n10 <= n10 - ONE;
            else if (coin_value == D5)  n5  <= n5 - ONE;
            else                        n1  <= n1 - ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_LOW_STOCK_EN
  // Low-stock flags track the counters one cycle behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) low_stock <= 4'b0000;
    else       low_stock <= {n50 < CNT_W'(LOW_THRESH), n10 < CNT_W'(LOW_THRESH),
                             n5 < CNT_W'(LOW_THRESH), n1 < CNT_W'(LOW_THRESH)};
  end
`else
  assign low_stock = 4'b0000;
`endif

endmodule
